// File: rtl/dmem_block_pkg.sv
// Shared types and width constants for the block-organised data memory.
// Every access moves one BLOCK_W-bit block made of BLOCK_BYTES byte lanes.
package dmem_block_pkg;

  localparam int BLOCK_BYTES = 4;
  localparam int BYTE_W      = 8;
  localparam int BLOCK_W     = BLOCK_BYTES * BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_block.sv
// Multi-cycle block data memory with a busywait handshake, serving cache
// miss-fill reads and dirty-block write-backs one 32-bit block at a time.
module dmem_block
  import dmem_block_pkg::*;
#(
  parameter int LATENCY    = 5,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [BLOCK_W-1:0]    writedata,
  output logic [BLOCK_W-1:0]    readdata,
  output logic                  busywait
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BLOCK_W-1:0]      wdata_q, wdata_d;
  logic                    is_write_q, is_write_d;
  logic [BLOCK_W-1:0]      readdata_q, readdata_d;
  logic                    mem_we;
  logic                    busy_raw;

  // Byte k of a block lives in bits [8k+7:8k] of the stored word.
  logic [BLOCK_W-1:0]      mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    readdata_d = readdata_q;
    mem_we     = 1'b0;
    busy_raw   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_raw = read | write;
        if (read | write) begin
          addr_d     = address;
          wdata_d    = writedata;
          is_write_d = write;
          count_d    = CNT_W'(LATENCY);
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy_raw = 1'b1;
        count_d  = count_q - CNT_W'(1);
        if (count_q <= CNT_W'(1)) begin
          count_d = '0;
          state_d = ST_DONE;
          if (is_write_q) mem_we = 1'b1;
          else            readdata_d = mem_q[addr_q];
        end
      end
      // The requester changes its request on this edge, so always go back.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset must silence the stall even though IDLE drives it combinationally.
  assign busywait = reset & busy_raw;
  assign readdata = readdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      readdata_q <= readdata_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_block.sv
// Scenario bench for dmem_block: expected readdata is pushed to a scoreboard
// queue when an access is issued and popped when busywait drops.
module tb_dmem_block;

  localparam int LAT = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [5:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        busywait;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [64];
  logic [31:0] last_rd;
  logic [31:0] sb_q [$];

  dmem_block #(.LATENCY(LAT), .ADDR_WIDTH(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait)
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    last_rd = 32'h0;
  endtask

  // Drive a request at the current time and push the readdata expected at completion.
  task automatic start_req(input logic rd, input logic wr, input logic [5:0] a,
                           input logic [31:0] d);
    read = rd;
    write = wr;
    address = a;
    writedata = d;
    if (wr) model_mem[a] = d;
    else    last_rd = model_mem[a];
    sb_q.push_back(last_rd);
    $display("txn rd=%0b wr=%0b addr=%02h wdata=%08h exp_rd=%08h", rd, wr, a, d, last_rd);
  endtask

  // Count negedge samples with busywait high, bounded; ends in the DONE cycle.
  task automatic wait_done(output int cyc);
    #1;
    cyc = 0;
    while (busywait === 1'b1 && cyc < 50) begin
      cyc++;
      @(negedge clock);
    end
  endtask

  task automatic drop_req();
    read = 1'b0;
    write = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    int cyc;
    logic [31:0] exp;
    model_clear();
    read = 1'b1;
    @(negedge clock);
    checks++;
    if (busywait !== 1'b0) begin
      errors++; $display("FAIL reset_busywait got=%0b exp=0", busywait);
    end
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL reset_readdata got=%08h exp=00000000", readdata);
    end
    reset = 1'b1;
    start_req(1'b1, 1'b0, 6'h00, 32'h0);
    wait_done(cyc);
    exp = sb_q.pop_front();
    checks++;
    if (cyc != LAT + 1) begin
      errors++; $display("FAIL reset_read_busy_cycles got=%0d exp=%0d", cyc, LAT + 1);
    end
    checks++;
    if (readdata !== exp) begin
      errors++; $display("FAIL reset_read_data got=%08h exp=%08h", readdata, exp);
    end
    drop_req();
    checks++;
    if (busywait !== 1'b0) begin
      errors++; $display("FAIL idle_busywait got=%0b exp=0", busywait);
    end
  endtask

  task automatic test_write_readback();
    int cyc;
    logic [31:0] exp;
    start_req(1'b0, 1'b1, 6'h05, 32'hDDCCBBAA);
    wait_done(cyc);
    exp = sb_q.pop_front();
    checks++;
    if (cyc != LAT + 1) begin
      errors++; $display("FAIL write05_busy_cycles got=%0d exp=%0d", cyc, LAT + 1);
    end
    checks++;
    if (readdata !== exp) begin
      errors++; $display("FAIL write05_readdata_kept got=%08h exp=%08h", readdata, exp);
    end
    drop_req();
    start_req(1'b1, 1'b0, 6'h05, 32'h0);
    wait_done(cyc);
    exp = sb_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++; $display("FAIL read05_data got=%08h exp=%08h", readdata, exp);
    end
    checks++;
    if (readdata[7:0] !== 8'hAA) begin
      errors++; $display("FAIL read05_lane0 got=%02h exp=aa", readdata[7:0]);
    end
    drop_req();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] exp;
    start_req(1'b0, 1'b1, 6'h3F, 32'h11223344);
    wait_done(cyc);
    exp = sb_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++; $display("FAIL wb_readdata_kept got=%08h exp=%08h", readdata, exp);
    end
    // Still in DONE: switch straight to the fill read.
    start_req(1'b1, 1'b0, 6'h3F, 32'h0);
    #1;
    checks++;
    if (busywait !== 1'b0) begin
      errors++; $display("FAIL done_busywait got=%0b exp=0", busywait);
    end
    @(negedge clock);
    wait_done(cyc);
    exp = sb_q.pop_front();
    checks++;
    if (cyc != LAT + 1) begin
      errors++; $display("FAIL fill_busy_cycles got=%0d exp=%0d", cyc, LAT + 1);
    end
    checks++;
    if (readdata !== exp) begin
      errors++; $display("FAIL fill_data got=%08h exp=%08h", readdata, exp);
    end
    drop_req();
  endtask

  task automatic test_input_change();
    int cyc;
    logic [31:0] exp;
    start_req(1'b0, 1'b1, 6'h06, 32'h12345678);
    wait_done(cyc);
    void'(sb_q.pop_front());
    drop_req();
    start_req(1'b1, 1'b0, 6'h05, 32'h0);
    @(negedge clock);
    address = 6'h06;
    writedata = 32'h55555555;
    wait_done(cyc);
    exp = sb_q.pop_front();
    checks++;
    if (cyc != LAT) begin
      errors++; $display("FAIL change_busy_cycles got=%0d exp=%0d", cyc, LAT);
    end
    checks++;
    if (readdata !== exp) begin
      errors++; $display("FAIL change_latched_addr got=%08h exp=%08h", readdata, exp);
    end
    drop_req();
  endtask

  task automatic test_simultaneous();
    int cyc;
    logic [31:0] exp;
    start_req(1'b1, 1'b1, 6'h10, 32'hCAFEF00D);
    wait_done(cyc);
    exp = sb_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++; $display("FAIL rw_readdata_kept got=%08h exp=%08h", readdata, exp);
    end
    drop_req();
    start_req(1'b1, 1'b0, 6'h10, 32'h0);
    wait_done(cyc);
    exp = sb_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++; $display("FAIL rw_written got=%08h exp=%08h", readdata, exp);
    end
    drop_req();
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    logic [31:0] exp;
    read = 1'b0;
    write = 1'b1;
    address = 6'h02;
    writedata = 32'hFFFFFFFF;
    $display("txn wr addr=02 wdata=ffffffff aborted by reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (busywait !== 1'b0) begin
      errors++; $display("FAIL abort_busywait got=%0b exp=0", busywait);
    end
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL abort_readdata got=%08h exp=00000000", readdata);
    end
    model_clear();
    write = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    start_req(1'b1, 1'b0, 6'h02, 32'h0);
    wait_done(cyc);
    exp = sb_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++; $display("FAIL abort_no_write got=%08h exp=%08h", readdata, exp);
    end
    drop_req();
    start_req(1'b1, 1'b0, 6'h05, 32'h0);
    wait_done(cyc);
    exp = sb_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++; $display("FAIL reset_cleared05 got=%08h exp=%08h", readdata, exp);
    end
    drop_req();
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_back_to_back();
    test_input_change();
    test_simultaneous();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
